// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache miss/fill path.
package dcache_pkg;

  localparam int unsigned ADDR_W         = 15;
  localparam int unsigned LINE_BYTES     = 8;
  localparam int unsigned BEATS_PER_LINE = 2;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned IDX_HI         = 14;
  localparam int unsigned IDX_LO         = 3;
  localparam int unsigned IDX_W          = IDX_HI - IDX_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BEAT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cacheable;
  } miss_entry_t;

  // Line fills start on the line boundary; uncached reads on the word boundary.
  function automatic logic [ADDR_W-1:0] bus_align(input logic [ADDR_W-1:0] a, input logic c);
    return c ? {a[ADDR_W-1:IDX_LO], 3'b000} : {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_miss_fill_ctrl_if.sv
// Miss request, memory bus, MSHR return and refill signals of the miss engine.
interface dcache_miss_fill_ctrl_if;
  import dcache_pkg::*;

  logic                  miss_vld;
  logic                  miss_rdy;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  miss_cacheable;
  logic                  bus_req;
  logic                  bus_gnt;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_rd_vld;
  logic [DATA_W-1:0]     bus_rd_data;
  logic                  mem_vld;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  fill_vld;
  logic [IDX_W-1:0]      fill_tag_idx;
  logic [2*DATA_W-1:0]   fill_data;
  logic                  busy;

  modport slave (
    input  miss_vld, miss_addr, miss_cacheable, bus_gnt, bus_rd_vld, bus_rd_data,
    output miss_rdy, bus_req, bus_addr, mem_vld, mem_addr, mem_data,
           fill_vld, fill_tag_idx, fill_data, busy
  );

  modport master (
    output miss_vld, miss_addr, miss_cacheable, bus_gnt, bus_rd_vld, bus_rd_data,
    input  miss_rdy, bus_req, bus_addr, mem_vld, mem_addr, mem_data,
           fill_vld, fill_tag_idx, fill_data, busy
  );

endinterface

// File: rtl/dcache_miss_fill_ctrl_miss_fifo.sv
// Register-based in-order miss queue; pointers wrap naturally since DEPTH is a power of two.
module miss_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
          mem_reg[gi] <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/dcache_miss_fill_ctrl.sv
// Miss engine: queues dcache misses and services them one at a time on the memory bus,
// returning the requested word to the MSHR and, for cacheable misses, the line to the array.
module dcache_miss_fill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  dcache_miss_fill_ctrl_if.slave  ifc
);
  localparam int unsigned ENTRY_W = ADDR_W + 1;

  state_t            state_reg, state_next;
  miss_entry_t       work_reg, work_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [1:0]        need_reg, need_next;
  logic [DATA_W-1:0] beat_reg  [BEATS_PER_LINE];
  logic [DATA_W-1:0] beat_next [BEATS_PER_LINE];

  logic                   fifo_pop;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  miss_entry_t            fifo_din;

  assign fifo_din = '{addr: ifc.miss_addr, cacheable: ifc.miss_cacheable};

  miss_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ifc.miss_vld && !fifo_full),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      need_reg  <= '0;
      beat_reg  <= '{default: '0};
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      need_reg  <= need_next;
      beat_reg  <= beat_next;
    end
  end

  // The head stays queued while in flight; it is popped only when its response retires.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    need_next  = need_reg;
    beat_next  = beat_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          work_next  = miss_entry_t'(fifo_dout);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ifc.bus_gnt) begin
          need_next  = work_reg.cacheable ? 2'd2 : 2'd1;
          cnt_next   = 2'd0;
          state_next = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (ifc.bus_rd_vld) begin
          beat_next[cnt_reg[0]] = ifc.bus_rd_data;
          cnt_next              = cnt_reg + 2'd1;
          if (cnt_reg + 2'd1 == need_reg)
            state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        fifo_pop   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic in_issue, in_resp, do_fill;
  assign in_issue = (state_reg == ST_ISSUE);
  assign in_resp  = (state_reg == ST_RESP);
  assign do_fill  = in_resp && work_reg.cacheable;

  assign ifc.miss_rdy     = !fifo_full;
  assign ifc.busy         = (state_reg != ST_IDLE) || (fifo_count != '0);
  assign ifc.bus_req      = in_issue;
  assign ifc.bus_addr     = in_issue ? bus_align(work_reg.addr, work_reg.cacheable) : '0;
  assign ifc.mem_vld      = in_resp;
  assign ifc.mem_addr     = in_resp ? work_reg.addr : '0;
  assign ifc.mem_data     = !in_resp ? '0 :
                            (work_reg.cacheable && work_reg.addr[2]) ? beat_reg[1] : beat_reg[0];
  assign ifc.fill_vld     = do_fill;
  assign ifc.fill_tag_idx = do_fill ? work_reg.addr[IDX_HI:IDX_LO] : '0;
  assign ifc.fill_data    = do_fill ? {beat_reg[1], beat_reg[0]} : '0;

endmodule

// File: tb/tb_dcache_miss_fill_ctrl.sv
// Directed bench for the miss engine; returns are checked against a scoreboard queue.
module tb_dcache_miss_fill_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_miss_fill_ctrl_if ifc();

  dcache_miss_fill_ctrl #(.DEPTH(4), .ADDR_W(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    logic        fill;
    logic [11:0] tag;
    logic [63:0] fdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every return pulse retires the oldest expected entry.
  always @(negedge clk) begin
    if (rst && ifc.mem_vld === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected mem_vld", 64'(ifc.mem_addr), 64'h7fff_ffff);
      end else begin
        mon_e = sb.pop_front();
        $display("ret addr=0x%04h data=0x%08h fill=%0d", ifc.mem_addr, ifc.mem_data, ifc.fill_vld);
        chk("mem_addr", 64'(ifc.mem_addr), 64'(mon_e.addr));
        chk("mem_data", 64'(ifc.mem_data), 64'(mon_e.data));
        chk("fill_vld", 64'(ifc.fill_vld), 64'(mon_e.fill));
        if (mon_e.fill) begin
          chk("fill_tag_idx", 64'(ifc.fill_tag_idx), 64'(mon_e.tag));
          chk("fill_data", ifc.fill_data, mon_e.fdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_miss(input logic [14:0] a, input logic c, input logic [31:0] d,
                           input logic [11:0] tag, input logic [63:0] fd);
    exp_t e;
    chk("miss_rdy before push", 64'(ifc.miss_rdy), 64'd1);
    e.addr = a; e.data = d; e.fill = c; e.tag = tag; e.fdata = fd;
    sb.push_back(e);
    ifc.miss_vld = 1'b1; ifc.miss_addr = a; ifc.miss_cacheable = c;
    step();
    ifc.miss_vld = 1'b0;
  endtask

  task automatic wait_req(input logic [14:0] exp_addr);
    int n = 0;
    while (ifc.bus_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("bus_req", 64'(ifc.bus_req), 64'd1);
    chk("bus_addr", 64'(ifc.bus_addr), 64'(exp_addr));
  endtask

  task automatic grant();
    ifc.bus_gnt = 1'b1;
    step();
    ifc.bus_gnt = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    ifc.bus_rd_vld = 1'b1; ifc.bus_rd_data = d;
    step();
    ifc.bus_rd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    chk("busy idle", 64'(ifc.busy), 64'd0);
  endtask

  initial begin
    ifc.miss_vld = 0; ifc.miss_addr = 0; ifc.miss_cacheable = 0;
    ifc.bus_gnt = 0; ifc.bus_rd_vld = 0; ifc.bus_rd_data = 0;
    step(); step();
    chk("reset miss_rdy", 64'(ifc.miss_rdy), 64'd1);
    chk("reset bus_req", 64'(ifc.bus_req), 64'd0);
    chk("reset mem_vld", 64'(ifc.mem_vld), 64'd0);
    chk("reset fill_vld", 64'(ifc.fill_vld), 64'd0);
    chk("reset busy", 64'(ifc.busy), 64'd0);
    rst = 1'b1;
    step();

    // 1: cacheable line fill, upper word requested
    push_miss(15'h1234, 1'b1, 32'hBBBB1111, 12'h246, 64'hBBBB1111_AAAA0000);
    wait_req(15'h1230);
    grant();
    beat(32'hAAAA0000);
    beat(32'hBBBB1111);
    wait_idle();

    // 2: uncached single-beat read
    push_miss(15'h0102, 1'b0, 32'hDEADBEEF, 12'h0, 64'h0);
    wait_req(15'h0100);
    grant();
    beat(32'hDEADBEEF);
    wait_idle();

    // 3: fill the queue while the bus withholds grant
    push_miss(15'h0200, 1'b1, 32'h11110000, 12'h040, 64'h11110001_11110000);
    push_miss(15'h0304, 1'b0, 32'h22220000, 12'h0,   64'h0);
    push_miss(15'h040C, 1'b1, 32'h33330001, 12'h081, 64'h33330001_33330000);
    push_miss(15'h0508, 1'b0, 32'h44440000, 12'h0,   64'h0);
    chk("miss_rdy full", 64'(ifc.miss_rdy), 64'd0);
    ifc.miss_vld = 1'b1; ifc.miss_addr = 15'h7000; ifc.miss_cacheable = 1'b1;
    step();
    ifc.miss_vld = 1'b0;
    chk("miss_rdy still full", 64'(ifc.miss_rdy), 64'd0);
    wait_req(15'h0200);
    grant();
    beat(32'h11110000);
    beat(32'h11110001);
    step();
    chk("miss_rdy after pop", 64'(ifc.miss_rdy), 64'd1);
    wait_req(15'h0304);
    grant();
    beat(32'h22220000);
    wait_req(15'h0408);
    grant();
    beat(32'h33330000);
    beat(32'h33330001);
    wait_req(15'h0508);
    grant();
    beat(32'h44440000);
    wait_idle();

    // 4: push on the same edge the RESP pops, with two entries queued
    push_miss(15'h0610, 1'b0, 32'h55550000, 12'h0,   64'h0);
    push_miss(15'h0618, 1'b1, 32'h66660000, 12'h0C3, 64'h66660001_66660000);
    wait_req(15'h0610);
    grant();
    beat(32'h55550000);
    push_miss(15'h0624, 1'b0, 32'h77770000, 12'h0, 64'h0);
    chk("count push+pop", 64'(u_dut.u_fifo.count_reg), 64'd2);
    wait_req(15'h0618);
    grant();
    beat(32'h66660000);
    beat(32'h66660001);
    wait_req(15'h0624);
    grant();
    beat(32'h77770000);
    wait_idle();

    // 5: spurious beats outside BEAT and a long grant stall
    beat(32'hBAD0BAD0);
    push_miss(15'h0714, 1'b1, 32'h88880001, 12'h0E2, 64'h88880001_88880000);
    wait_req(15'h0710);
    beat(32'hBAD1BAD1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall bus_req", 64'(ifc.bus_req), 64'd1);
      chk("stall bus_addr", 64'(ifc.bus_addr), 64'h0710);
    end
    grant();
    beat(32'h88880000);
    beat(32'h88880001);
    wait_idle();

    // 6: reset lands between the two beats of a line fill
    push_miss(15'h0800, 1'b1, 32'h0, 12'h100, 64'h0);
    push_miss(15'h0900, 1'b0, 32'h0, 12'h0, 64'h0);
    wait_req(15'h0800);
    grant();
    beat(32'h99990000);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("rst bus_req", 64'(ifc.bus_req), 64'd0);
    chk("rst mem_vld", 64'(ifc.mem_vld), 64'd0);
    chk("rst fill_vld", 64'(ifc.fill_vld), 64'd0);
    chk("rst busy", 64'(ifc.busy), 64'd0);
    chk("rst miss_rdy", 64'(ifc.miss_rdy), 64'd1);
    chk("rst queue count", 64'(u_dut.u_fifo.count_reg), 64'd0);
    step(); step();
    rst = 1'b1;
    step();
    push_miss(15'h0A04, 1'b1, 32'hAAAA0001, 12'h140, 64'hAAAA0001_AAAA0000);
    wait_req(15'h0A00);
    grant();
    beat(32'hAAAA0000);
    beat(32'hAAAA0001);
    wait_idle();

    step();
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
